// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep checker: drives dut_in 0..2**N_IN-1, samples dut_out, compares to EXPECTED.
// Latency: SETTLE_CYCLES+1 cycles per vector; done pulses 2**N_IN*(SETTLE_CYCLES+1) cycles after the start edge.
// No backpressure: start is ignored unless IDLE. Optional TT_SWEEP_CAPTURE_EN adds the measured-table port 'captured'.
module tt_sweep_checker #(
    parameter int N_IN = 3,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = 8'hE8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            dut_out,
    output logic [N_IN-1:0] dut_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_idx
`ifdef TT_SWEEP_CAPTURE_EN
    ,
    output logic [(1<<N_IN)-1:0] captured
`endif
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            last_vec;
    logic            mismatch;
    logic [N_IN:0]   err_nxt;

    assign last_vec = (dut_in == {N_IN{1'b1}});
    assign mismatch = (dut_out != EXPECTED[dut_in]);
    assign err_nxt  = err_count + {{N_IN{1'b0}}, mismatch};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (cnt == '0) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = last_vec ? DONE : SETTLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SETTLE) || (state == SAMPLE);
        done = (state == DONE);
    end

    // pass is registered on the way into DONE so it includes the final vector and then holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            dut_in           <= '0;
            cnt              <= '0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
`ifdef TT_SWEEP_CAPTURE_EN
            captured         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dut_in           <= '0;
                        cnt              <= CNT_LOAD;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_idx   <= '0;
`ifdef TT_SWEEP_CAPTURE_EN
                        captured         <= '0;
`endif
                    end
                end
                SETTLE: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                SAMPLE: begin
                    err_count <= err_nxt;
                    if (mismatch && !first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_idx   <= dut_in;
                    end
`ifdef TT_SWEEP_CAPTURE_EN
                    captured[dut_in] <= dut_out;
`endif
                    if (last_vec) begin
                        pass <= (err_nxt == '0);
                    end else begin
                        dut_in <= dut_in + N_IN'(1);
                        cnt    <= CNT_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
